// File: rtl/rv32_muldiv_sequencer.sv
// rv32_muldiv_sequencer
//   Multi-cycle sequencer for the RV32 M extension (MUL/MULH/MULHSU/MULHU,
//   DIV/DIVU/REM/REMU). It runs an iterative shift-add multiplier or a
//   restoring divider, and stalls the PC and register writeback until the
//   result is ready.
//
//   Optional build macro: RV32_MUL_FASTPATH_EN
//     defined   : MUL* ops use a single-cycle 33x33 signed multiplier
//                 (IDLE -> DONE). DIV* ops are unchanged.
//     undefined : MUL* ops iterate one bit per cycle (XLEN cycles).
//
// Ports
//   clk        core clock
//   rst_n      synchronous active-low reset
//   m_valid_i  decoded M-ext instruction present (held while stall_o=1)
//   m_op_i     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//   rs1_i      operand A (multiplicand / dividend)
//   rs2_i      operand B (multiplier / divisor)
//   flush_i    abort any in-flight op; the FSM returns to IDLE next cycle
//   stall_o    freeze PC and block reg_write this cycle
//   busy_o     FSM not in IDLE
//   done_o     one-cycle pulse; result_o is valid for writeback
//   result_o   M-ext result, held until the next completion
module rv32_muldiv_sequencer #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            m_valid_i,
   input  logic [2:0]      m_op_i,
   input  logic [XLEN-1:0] rs1_i,
   input  logic [XLEN-1:0] rs2_i,
   input  logic            flush_i,
   output logic            stall_o,
   output logic            busy_o,
   output logic            done_o,
   output logic [XLEN-1:0] result_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } state_e;

   localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

   state_e              state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [XLEN-1:0]     opnd_q, opnd_d;      // |rs1| for MUL, |rs2| for DIV
   logic [2*XLEN-1:0]   acc_q, acc_d;        // MUL: {hi, multiplier}; DIV: {rem, quo}
   logic                neg_q, neg_d;        // negate the result on completion
   logic                sel_hi_q, sel_hi_d;  // pick the upper half (MULH*, REM*)
   logic                is_div_q, is_div_d;  // divide: negate 32-bit pick, not 64-bit acc
   logic [XLEN-1:0]     result_q, result_d;

   // Operand decode for a new instruction
   logic            sign_a, sign_b, sa, sb;
   logic [XLEN-1:0] mag_a, mag_b;
   logic            is_rem, is_mulh, div_zero, div_ovf;

   always_comb begin
      sign_a   = m_op_i[2] ? ~m_op_i[0] : (m_op_i[1:0] != 2'b11);
      sign_b   = m_op_i[2] ? ~m_op_i[0] : ~m_op_i[1];
      sa       = sign_a & rs1_i[XLEN-1];
      sb       = sign_b & rs2_i[XLEN-1];
      mag_a    = sa ? -rs1_i : rs1_i;
      mag_b    = sb ? -rs2_i : rs2_i;
      is_rem   = m_op_i[2] & m_op_i[1];
      is_mulh  = ~m_op_i[2] & (m_op_i[1:0] != 2'b00);
      div_zero = (rs2_i == '0);
      div_ovf  = ~m_op_i[0] & (rs1_i == INT_MIN) & (rs2_i == '1);
   end

`ifdef RV32_MUL_FASTPATH_EN
   // 33x33 signed product; only the low 2*XLEN bits are ever needed, so the
   // sign-extended operands are multiplied at that width.
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
   always_comb begin
      fast_a    = {{XLEN{sa}}, rs1_i};
      fast_b    = {{XLEN{sb}}, rs2_i};
      fast_prod = fast_a * fast_b;
   end
`endif

   // Iteration datapath
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [XLEN:0]     div_shift;
   logic [XLEN-1:0]   div_diff;
   logic              div_ge;
   logic [2*XLEN-1:0] div_next;

   always_comb begin
      mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
      mul_next  = {mul_sum, acc_q[XLEN-1:1]};
      div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_ge    = (div_shift >= {1'b0, opnd_q});
      // The partial remainder is always below the divisor, so the difference
      // fits in XLEN bits whenever it is kept.
      div_diff  = div_shift[XLEN-1:0] - opnd_q;
      div_next  = {div_ge ? div_diff : div_shift[XLEN-1:0], acc_q[XLEN-2:0], div_ge};
   end

   // Final sign fix-up and half selection
   logic [2*XLEN-1:0] full_val;
   logic [XLEN-1:0]   pick_val, final_val;

   always_comb begin
      full_val  = (neg_q & ~is_div_q) ? -acc_q : acc_q;
      pick_val  = sel_hi_q ? full_val[2*XLEN-1:XLEN] : full_val[XLEN-1:0];
      final_val = (neg_q & is_div_q) ? -pick_val : pick_val;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         opnd_q   <= '0;
         acc_q    <= '0;
         neg_q    <= 1'b0;
         sel_hi_q <= 1'b0;
         is_div_q <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         opnd_q   <= opnd_d;
         acc_q    <= acc_d;
         neg_q    <= neg_d;
         sel_hi_q <= sel_hi_d;
         is_div_q <= is_div_d;
         result_q <= result_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      opnd_d   = opnd_q;
      acc_d    = acc_q;
      neg_d    = neg_q;
      sel_hi_d = sel_hi_q;
      is_div_d = is_div_q;
      result_d = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (m_valid_i) begin
               cnt_d    = CNT_W'(XLEN - 1);
               sel_hi_d = m_op_i[2] ? is_rem : is_mulh;
               is_div_d = m_op_i[2];
               if (m_op_i[2]) begin
                  // Special cases are parked in acc so the normal fix-up
                  // path (with no negation) yields the architectural value.
                  if (div_zero) begin
                     acc_d   = {rs1_i, {XLEN{1'b1}}};
                     neg_d   = 1'b0;
                     state_d = S_DONE;
                  end else if (div_ovf) begin
                     acc_d   = {{XLEN{1'b0}}, INT_MIN};
                     neg_d   = 1'b0;
                     state_d = S_DONE;
                  end else begin
                     acc_d   = {{XLEN{1'b0}}, mag_a};
                     opnd_d  = mag_b;
                     neg_d   = is_rem ? sa : (sa ^ sb);
                     state_d = S_DIV;
                  end
               end else begin
`ifdef RV32_MUL_FASTPATH_EN
                  acc_d   = fast_prod;
                  neg_d   = 1'b0;
                  state_d = S_DONE;
`else
                  acc_d   = {{XLEN{1'b0}}, mag_b};
                  opnd_d  = mag_a;
                  neg_d   = sa ^ sb;
                  state_d = S_MUL;
`endif
               end
            end
         end
         S_MUL: begin
            acc_d = mul_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = S_DONE;
         end
         S_DIV: begin
            acc_d = div_next;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = S_DONE;
         end
         S_DONE: begin
            state_d = S_IDLE;
            if (!flush_i) result_d = final_val;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush_i) state_d = S_IDLE;
   end

   // Outputs
   always_comb begin
      busy_o = (state_q != S_IDLE);
      done_o = (state_q == S_DONE) & ~flush_i;
      unique case (state_q)
         S_IDLE:       stall_o = m_valid_i & ~flush_i;
         S_MUL, S_DIV: stall_o = ~flush_i;
         default:      stall_o = 1'b0;
      endcase
      result_o = done_o ? final_val : result_q;
   end

endmodule
